expande_chave_seq: RTL

Sequential, parametrised AES key expander: accepts a 128/192/256-bit cipher key and streams the NR+1 round keys, one 128-bit round key per valid/ready transfer, in ascending round order. It generates one 32-bit schedule word per clock using a single SubWord datapath, so area stays flat across key sizes. It sits between the key register and the round datapath, and replaces the combinational single-round expander for all key sizes.

---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/sub_palavra.sv | 14 +
 rtl/expande_chave_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES tables and helpers for the sequential key expander.
// Holds the S-box, xtime, RCON_INIT, the FSM state type and the NK legality check.
package aes_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    GERA   = 2'd1,
    DRENA  = 2'd2
  } estado_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8); 0x80 wraps to 0x1B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic bit nk_legal(input int nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

endpackage

// File: rtl/sub_palavra.sv
// sub_palavra: SubWord, four parallel S-box lookups on a 32-bit word.
// Ports: palavra_i word in, palavra_o substituted word out (combinational).
module sub_palavra
  import aes_pkg::*;
(
  input  logic [31:0] palavra_i,
  output logic [31:0] palavra_o
);

  for (genvar k = 0; k < 4; k++) begin : g_byte
    assign palavra_o[8*k +: 8] = sbox(palavra_i[8*k +: 8]);
  end

endmodule

// File: rtl/expande_chave_seq.sv
// expande_chave_seq: sequential AES key expander, one schedule word per clock,
// streaming NR+1 round keys over valid/ready. Optional macro EXPANDE_CHAVE_ABORTA_EN
// lets inicio abort and restart a busy run.
// Ports: clk, rst (async high), inicio/chave start+key, ocupado busy,
// rk_valido/rk_pronto handshake, rk_dado/rk_indice/rk_ultimo round key.
module expande_chave_seq
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic [255:0] chave,
  output logic         ocupado,
  output logic         rk_valido,
  input  logic         rk_pronto,
  output logic [127:0] rk_dado,
  output logic [3:0]   rk_indice,
  output logic         rk_ultimo
);

  localparam int         NR     = NK + 6;
  localparam int         NW     = 4 * (NR + 1);
  localparam logic [5:0] I_LAST = 6'(NW - 1);
  localparam logic [2:0] J_MAX  = 3'(NK - 1);
  localparam logic [3:0] R_LAST = 4'(NR);

  if (!nk_legal(NK)) begin : g_nk_ilegal
    $error("expande_chave_seq: NK must be 4, 6 or 8");
  end

  estado_e      st_q, st_d;
  logic [31:0]  win_q [NK];
  logic [31:0]  win_d [NK];
  logic [31:0]  acc_q [3];
  logic [31:0]  acc_d [3];
  logic [5:0]   i_q, i_d;
  logic [2:0]   j_q, j_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         vld_q, vld_d;
  logic [127:0] dado_q, dado_d;
  logic [3:0]   idx_q, idx_d;

  logic [31:0] ant;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] w_nova;
  logic        eh_chave;
  logic        j_zero;
  logic        j_quatro;
  logic        xfer;
  logic        grupo_fim;
  logic        stall;
  logic        avanca;
  logic        inicia;

  // Short keys leave the low chave bits unread.
  logic unused_chave;
  assign unused_chave = ^chave;

  // The window doubles as key buffer: it is loaded with the key words,
  // so for i < NK the oldest slot already is key word i.
  assign ant      = win_q[NK-1];
  assign eh_chave = (i_q < 6'(NK));
  assign j_zero   = (j_q == 3'd0);
  assign j_quatro = (NK == 8) && (j_q == 3'd4);
  assign sub_in   = j_zero ? {ant[23:0], ant[31:24]} : ant;

  sub_palavra u_sub (
    .palavra_i (sub_in),
    .palavra_o (sub_out)
  );

  always_comb begin
    w_nova = win_q[0] ^ ant;
    if (eh_chave) begin
      w_nova = win_q[0];
    end else if (j_zero) begin
      w_nova = win_q[0] ^ sub_out ^ {rcon_q, 24'h0};
    end else if (j_quatro) begin
      w_nova = win_q[0] ^ sub_out;
    end
  end

  assign xfer      = vld_q && rk_pronto;
  assign grupo_fim = (i_q[1:0] == 2'd3);
  // A finished group cannot land while the output is still owned.
  assign stall     = grupo_fim && vld_q && !rk_pronto;
  assign avanca    = (st_q == GERA) && !stall;

`ifdef EXPANDE_CHAVE_ABORTA_EN
  assign inicia = inicio;
`else
  assign inicia = inicio && (st_q == OCIOSO);
`endif

  always_comb begin
    st_d   = st_q;
    win_d  = win_q;
    acc_d  = acc_q;
    i_d    = i_q;
    j_d    = j_q;
    rcon_d = rcon_q;
    vld_d  = vld_q;
    dado_d = dado_q;
    idx_d  = idx_q;

    if (xfer) vld_d = 1'b0;

    unique case (st_q)
      OCIOSO: begin
      end
      GERA: begin
        if (avanca) begin
          for (int k = 0; k < NK - 1; k++) win_d[k] = win_q[k+1];
          win_d[NK-1] = w_nova;
          acc_d[0] = acc_q[1];
          acc_d[1] = acc_q[2];
          acc_d[2] = w_nova;
          i_d = i_q + 6'd1;
          j_d = (j_q == J_MAX) ? 3'd0 : j_q + 3'd1;
          if (!eh_chave && j_zero) rcon_d = xtime(rcon_q);
          // Reload may coincide with a transfer: no bubble.
          if (grupo_fim) begin
            dado_d = {acc_q[0], acc_q[1], acc_q[2], w_nova};
            idx_d  = i_q[5:2];
            vld_d  = 1'b1;
          end
          if (i_q == I_LAST) st_d = DRENA;
        end
      end
      DRENA: begin
        if (xfer) st_d = OCIOSO;
      end
      default: st_d = OCIOSO;
    endcase

    if (inicia) begin
      st_d   = GERA;
      i_d    = 6'd0;
      j_d    = 3'd0;
      rcon_d = RCON_INIT;
      vld_d  = 1'b0;
      for (int k = 0; k < NK; k++) win_d[k] = chave[255-32*k -: 32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= OCIOSO;
      i_q    <= 6'd0;
      j_q    <= 3'd0;
      rcon_q <= 8'h00;
      vld_q  <= 1'b0;
      dado_q <= '0;
      idx_q  <= 4'd0;
      for (int k = 0; k < NK; k++) win_q[k] <= '0;
      for (int k = 0; k < 3; k++) acc_q[k] <= '0;
    end else begin
      st_q   <= st_d;
      i_q    <= i_d;
      j_q    <= j_d;
      rcon_q <= rcon_d;
      vld_q  <= vld_d;
      dado_q <= dado_d;
      idx_q  <= idx_d;
      for (int k = 0; k < NK; k++) win_q[k] <= win_d[k];
      for (int k = 0; k < 3; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign ocupado   = (st_q != OCIOSO);
  assign rk_valido = vld_q;
  assign rk_dado   = dado_q;
  assign rk_indice = idx_q;
  assign rk_ultimo = vld_q && (idx_q == R_LAST);

endmodule
